oup_ulpi_phy_responder: RTL and testbench

//  PHY-side end of the ULPI link: responds to link-issued TX CMDs (register write/read, transmit) and

---
 rtl/oup_ulpi_phy_responder.sv | 156 +++++++++++++++
 tb/tb_oup_ulpi_phy_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/oup_ulpi_phy_responder.sv
// PHY side of a ULPI link: answers link TX CMDs (register write/read, transmit)
// and raises RX CMDs when the line state changes.
module oup_ulpi_phy_responder #(
  parameter logic [15:0] VENDOR_ID  = 16'h0424,
  parameter logic [15:0] PRODUCT_ID = 16'h0009
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe_o,
  output logic       ulpi_dir_o,
  input  logic       ulpi_stp_i,
  output logic       ulpi_nxt_o,
  input  logic [1:0] linestate_i,
  output logic [7:0] func_ctrl_o,
  output logic [7:0] if_ctrl_o,
  output logic [7:0] otg_ctrl_o,
  output logic       phy_reset_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ACC, S_WR_DAT, S_WR_STP,
    S_RD_ACC, S_RD_TA1, S_RD_DAT, S_RD_TA2,
    S_TX, S_RX_TA1, S_RX_DAT, S_RX_TA2
  } state_t;

  state_t     state, state_n;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [1:0] reported;
  logic [7:0] func_ctrl, if_ctrl, otg_ctrl, scratch;
  logic [7:0] rd_data;
  logic       commit;

  assign func_ctrl_o = func_ctrl;
  assign if_ctrl_o   = if_ctrl;
  assign otg_ctrl_o  = otg_ctrl;
  assign commit      = (state == S_WR_STP) && ulpi_stp_i;

  always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n        = state;
    ulpi_dir_o     = 1'b0;
    ulpi_data_oe_o = 1'b0;
    ulpi_nxt_o     = 1'b0;
    ulpi_data_o    = '0;
    case (state)
      S_IDLE: begin
        // A TX CMD always wins; a line change is only reported on a quiet bus.
        case (ulpi_data_i[7:6])
          2'b10:   state_n = S_WR_ACC;
          2'b11:   state_n = S_RD_ACC;
          2'b01:   state_n = S_TX;
          default: if (ulpi_data_i == 8'h00 && linestate_i != reported) state_n = S_RX_TA1;
        endcase
      end
      S_WR_ACC: begin
        ulpi_nxt_o = 1'b1;
        state_n    = ulpi_stp_i ? S_IDLE : S_WR_DAT;
      end
      S_WR_DAT: begin
        ulpi_nxt_o = 1'b1;
        state_n    = ulpi_stp_i ? S_IDLE : S_WR_STP;
      end
      S_WR_STP: if (ulpi_stp_i) state_n = S_IDLE;
      S_RD_ACC: begin
        ulpi_nxt_o = 1'b1;
        state_n    = ulpi_stp_i ? S_IDLE : S_RD_TA1;
      end
      S_RD_TA1: begin
        ulpi_dir_o = 1'b1;
        state_n    = S_RD_DAT;
      end
      S_RD_DAT: begin
        ulpi_dir_o     = 1'b1;
        ulpi_data_oe_o = 1'b1;
        ulpi_data_o    = rd_data;
        state_n        = S_RD_TA2;
      end
      S_RD_TA2: state_n = S_IDLE;
      S_TX: begin
        ulpi_nxt_o = 1'b1;
        if (ulpi_stp_i) state_n = S_IDLE;
      end
      S_RX_TA1: begin
        ulpi_dir_o = 1'b1;
        state_n    = S_RX_DAT;
      end
      S_RX_DAT: begin
        ulpi_dir_o     = 1'b1;
        ulpi_data_oe_o = 1'b1;
        ulpi_data_o    = {6'b0, reported};
        state_n        = S_RX_TA2;
      end
      S_RX_TA2: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      6'h00:               rd_data = VENDOR_ID[7:0];
      6'h01:               rd_data = VENDOR_ID[15:8];
      6'h02:               rd_data = PRODUCT_ID[7:0];
      6'h03:               rd_data = PRODUCT_ID[15:8];
      6'h04, 6'h05, 6'h06: rd_data = func_ctrl;
      6'h07, 6'h08, 6'h09: rd_data = if_ctrl;
      6'h0A, 6'h0B, 6'h0C: rd_data = otg_ctrl;
      6'h16, 6'h17, 6'h18: rd_data = scratch;
      default:             rd_data = '0;
    endcase
  end

  always_ff @(posedge ulpi_clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr        <= '0;
      wdata       <= '0;
      reported    <= '0;
      func_ctrl   <= 8'h41;
      if_ctrl     <= '0;
      otg_ctrl    <= 8'h06;
      scratch     <= '0;
      phy_reset_o <= 1'b0;
    end else begin
      if (state == S_IDLE)   addr     <= ulpi_data_i[5:0];
      if (state == S_WR_DAT) wdata    <= ulpi_data_i;
      if (state == S_RX_TA1) reported <= linestate_i;
      // FuncCtrl bit 5 is a reset strobe: it is never stored, only pulsed out.
      phy_reset_o <= commit && (addr == 6'h04 || addr == 6'h05) && wdata[5];
      if (commit) begin
        case (addr)
          6'h04:   func_ctrl <= wdata & 8'hDF;
          6'h05:   func_ctrl <= (func_ctrl | wdata) & 8'hDF;
          6'h06:   func_ctrl <= func_ctrl & ~wdata;
          6'h07:   if_ctrl   <= wdata;
          6'h08:   if_ctrl   <= if_ctrl | wdata;
          6'h09:   if_ctrl   <= if_ctrl & ~wdata;
          6'h0A:   otg_ctrl  <= wdata;
          6'h0B:   otg_ctrl  <= otg_ctrl | wdata;
          6'h0C:   otg_ctrl  <= otg_ctrl & ~wdata;
          6'h16:   scratch   <= wdata;
          6'h17:   scratch   <= scratch | wdata;
          6'h18:   scratch   <= scratch & ~wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oup_ulpi_phy_responder.sv
// Self-checking bench for oup_ulpi_phy_responder: scripted link transactions,
// with every PHY-driven bus byte checked against a queue of expected values.
module tb_oup_ulpi_phy_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ulpi_data_i;
  logic [7:0] ulpi_data_o;
  logic       ulpi_data_oe;
  logic       ulpi_dir;
  logic       ulpi_stp;
  logic       ulpi_nxt;
  logic [1:0] linestate;
  logic [7:0] func_ctrl, if_ctrl, otg_ctrl;
  logic       phy_reset;

  int tests  = 0;
  int failed = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  oup_ulpi_phy_responder #(
    .VENDOR_ID (16'h0424),
    .PRODUCT_ID(16'h0009)
  ) dut (
    .ulpi_clk_i    (clk),
    .rst_i         (rst),
    .ulpi_data_i   (ulpi_data_i),
    .ulpi_data_o   (ulpi_data_o),
    .ulpi_data_oe_o(ulpi_data_oe),
    .ulpi_dir_o    (ulpi_dir),
    .ulpi_stp_i    (ulpi_stp),
    .ulpi_nxt_o    (ulpi_nxt),
    .linestate_i   (linestate),
    .func_ctrl_o   (func_ctrl),
    .if_ctrl_o     (if_ctrl),
    .otg_ctrl_o    (otg_ctrl),
    .phy_reset_o   (phy_reset)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every cycle the PHY drives the bus must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ulpi_data_oe) begin
      if (sb_q.size() == 0) check("unexpected_bus_drive", {24'b0, ulpi_data_o}, 32'hDEAD);
      else                  check("bus_data", {24'b0, ulpi_data_o}, {24'b0, sb_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input bit abort2,
                          input bit exp_rst);
    tick(); ulpi_data_i = {2'b10, a};                                   // N
    tick(); check("wr_nxt_n1", ulpi_nxt, 1); ulpi_data_i = d;           // N+1
    tick(); check("wr_nxt_n2", ulpi_nxt, 1); if (abort2) ulpi_stp = 1'b1; // N+2
    tick(); ulpi_data_i = 8'h00;                                        // N+3
    if (abort2) begin
      ulpi_stp = 1'b0;
      check("wr_abort_nxt", ulpi_nxt, 0);
      check("wr_abort_dir", ulpi_dir, 0);
      return;
    end
    check("wr_nxt_n3", ulpi_nxt, 0);
    ulpi_stp = 1'b1;
    tick(); ulpi_stp = 1'b0;                                            // N+4
    check("wr_phy_reset", phy_reset, exp_rst);
    check("wr_dir_idle", ulpi_dir, 0);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [7:0] exp,
                         input bit chg_ls, input logic [1:0] ls);
    tick(); ulpi_data_i = {2'b11, a};                                   // N
    sb_q.push_back(exp);
    if (chg_ls) begin
      linestate = ls;
      sb_q.push_back({6'b0, ls});
    end
    tick(); ulpi_data_i = 8'h00;                                        // N+1
    check("rd_nxt_n1", ulpi_nxt, 1);
    check("rd_dir_n1", ulpi_dir, 0);
    tick();                                                             // N+2
    check("rd_dir_n2", ulpi_dir, 1);
    check("rd_oe_n2", ulpi_data_oe, 0);
    tick();                                                             // N+3
    check("rd_dir_n3", ulpi_dir, 1);
    check("rd_oe_n3", ulpi_data_oe, 1);
    tick();                                                             // N+4
    check("rd_dir_n4", ulpi_dir, 0);
    check("rd_oe_n4", ulpi_data_oe, 0);
    tick();                                                             // N+5
    check("rd_dir_n5", ulpi_dir, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, failed + 1);
  end

  initial begin
    rst = 1'b1; ulpi_data_i = 8'h00; ulpi_stp = 1'b0; linestate = 2'b00;
    repeat (3) tick();
    check("rst_dir", ulpi_dir, 0);
    check("rst_nxt", ulpi_nxt, 0);
    check("rst_oe", ulpi_data_oe, 0);
    check("rst_func", func_ctrl, 8'h41);
    check("rst_if", if_ctrl, 8'h00);
    check("rst_otg", otg_ctrl, 8'h06);
    rst = 1'b0;
    tick();

    do_read(6'h00, 8'h24, 0, 2'b00);
    do_read(6'h01, 8'h04, 0, 2'b00);
    do_read(6'h03, 8'h00, 0, 2'b00);

    do_write(6'h16, 8'hA5, 0, 0);
    do_write(6'h17, 8'h0F, 0, 0);
    do_write(6'h18, 8'h05, 0, 0);
    do_read(6'h16, 8'hAA, 0, 2'b00);

    do_write(6'h04, 8'h20, 0, 1);
    tick(); check("phy_reset_single", phy_reset, 0);
    check("func_after_rst_bit", func_ctrl, 8'h00);
    do_read(6'h04, 8'h00, 0, 2'b00);

    do_write(6'h07, 8'h55, 1, 0);
    tick(); check("if_after_abort", if_ctrl, 8'h00);
    do_write(6'h2F, 8'hFF, 0, 0);
    do_read(6'h2F, 8'h00, 0, 2'b00);
    do_write(6'h01, 8'hFF, 0, 0);
    do_read(6'h01, 8'h04, 0, 2'b00);

    // Transmit: nxt held high up to and including the stp cycle.
    tick(); ulpi_data_i = 8'h41;
    tick(); ulpi_data_i = 8'h12; check("tx_nxt1", ulpi_nxt, 1);
    tick(); ulpi_data_i = 8'h34; check("tx_nxt2", ulpi_nxt, 1); ulpi_stp = 1'b1;
    tick(); ulpi_data_i = 8'h00; ulpi_stp = 1'b0; check("tx_nxt_idle", ulpi_nxt, 0);

    // Line state change on an idle bus.
    linestate = 2'b01; sb_q.push_back(8'h01);
    tick(); check("rx_dir_m", ulpi_dir, 1); check("rx_oe_m", ulpi_data_oe, 0);
    tick(); check("rx_oe_m1", ulpi_data_oe, 1);
    tick(); check("rx_dir_m2", ulpi_dir, 0);
    tick();

    // Read command and line change in the same cycle: read first, RX CMD after.
    do_read(6'h16, 8'hAA, 1, 2'b10);
    repeat (4) tick();
    check("rx_after_read_dir", ulpi_dir, 0);

    // Reset in the data cycle of a read.
    do_write(6'h0A, 8'h3C, 0, 0);
    check("otg_written", otg_ctrl, 8'h3C);
    tick(); ulpi_data_i = {2'b11, 6'h0A};
    tick(); ulpi_data_i = 8'h00;
    tick();
    tick(); check("pre_rst_dir", ulpi_dir, 1);
    linestate = 2'b00; rst = 1'b1;
    #1;
    check("rst_mid_dir", ulpi_dir, 0);
    check("rst_mid_oe", ulpi_data_oe, 0);
    tick(); rst = 1'b0;
    check("otg_after_rst", otg_ctrl, 8'h06);
    do_read(6'h0A, 8'h06, 0, 2'b00);

    repeat (3) tick();
    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
